alu_sequencer: RTL and testbench

- Multi-cycle control and operand stage directly upstream of the 8-bit ALU (AND/XOR/ADD/circular-left-shift, with CO and Z outputs).
- Fetches 12-bit instructions from a synchronous instruction ROM and holds a 4x8 register file.
- Drives the ALU operand and select inputs, then writes the ALU result and flags back.
- Sole sequencer of the single-purpose processor; the ALU stays purely combinational.

---
 rtl/alu_seq_pkg.sv | 35 +++
 rtl/alu_seq_regfile.sv | 25 ++
 rtl/alu_sequencer.sv | 114 +++++++++++
 tb/tb_alu_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared states, opcode fields and constants for the ALU sequencer
package alu_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;
  localparam int DW = 8;
  localparam int NREGS = 4;
  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_LDI = 2'b01;
  localparam logic [1:0] CLS_BR = 2'b10;
  localparam logic [1:0] CLS_HALT = 2'b11;
  localparam logic [1:0] SEL_AND = 2'b00;
  localparam logic [1:0] SEL_XOR = 2'b01;
  localparam logic [1:0] SEL_ADD = 2'b10;
  localparam logic [1:0] SEL_SHIFT = 2'b11;
  localparam logic [1:0] BR_ALWAYS = 2'b00;
  localparam logic [1:0] BR_Z = 2'b01;
  localparam logic [1:0] BR_CO = 2'b10;
  localparam logic [1:0] BR_NEVER = 2'b11;
  localparam int CLS_LSB = 10;
  localparam int SEL_LSB = 8;
  localparam int RD_LSB = 6;
  localparam int RS_LSB = 4;
  localparam int LDI_RD_LSB = 8;
  localparam int COND_LSB = 8;
  function automatic logic br_taken(input logic [1:0] cond, input logic z, input logic co);
    return (cond == BR_ALWAYS) || (cond == BR_Z && z) || (cond == BR_CO && co);
  endfunction
endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: 4x8 register file, two combinational read ports, one synchronous write port
//   clk, rst      : clock, synchronous active-high reset (clears all registers)
//   we, wa, wd    : write enable, write address, write data
//   ra, rb        : read addresses
//   a_data, b_data: read data
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [1:0]    wa,
  input  logic [DW-1:0] wd,
  input  logic [1:0]    ra,
  input  logic [1:0]    rb,
  output logic [DW-1:0] a_data,
  output logic [DW-1:0] b_data
);
  logic [DW-1:0] regs [NREGS];
  always_ff @(posedge clk)
    if (rst) regs <= '{default: '0};
    else if (we) regs[wa] <= wd;
  assign a_data = regs[ra];
  assign b_data = regs[rb];
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/decode/execute sequencer driving an external combinational ALU
//   clk, rst                 : clock, synchronous active-high reset
//   start                    : begins execution from IDLE or HALT
//   rom_addr, rom_data       : instruction ROM port (data valid one cycle after address)
//   alu_a, alu_b, alu_sel    : ALU operands and select
//   alu_out, alu_co, alu_z   : ALU result and flags
//   flag_z, flag_co          : registered flags
//   busy, halted             : status
//   retired_cnt              : saturating retired-instruction count (only with ALU_SEQ_PERF_EN)
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int IW = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] rom_addr,
  input  logic [IW-1:0]   rom_data,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [1:0]      alu_sel,
  input  logic [DW-1:0]   alu_out,
  input  logic            alu_co,
  input  logic            alu_z,
  output logic            flag_z,
  output logic            flag_co,
  output logic            busy,
`ifdef ALU_SEQ_PERF_EN
  output logic [15:0]     retired_cnt,
`endif
  output logic            halted
);
  state_t state, next;
  logic [PC_W-1:0] pc;
  logic [IW-1:0] ir;
  logic [DW-1:0] a_q, b_q, a_data, b_data, wd;
  logic [1:0] sel_q, cls, wa;
  logic alu_drive, we, taken;
  assign cls = ir[CLS_LSB +: 2];
  assign taken = br_taken(ir[COND_LSB +: 2], flag_z, flag_co);
  // Operands track the register file live during EXEC/WB of an ALU op and are frozen otherwise.
  assign alu_drive = (state == S_EXEC || state == S_WB) && cls == CLS_ALU;
  assign alu_a = alu_drive ? a_data : a_q;
  assign alu_b = alu_drive ? b_data : b_q;
  assign alu_sel = alu_drive ? ir[SEL_LSB +: 2] : sel_q;
  assign we = (state == S_EXEC && cls == CLS_LDI) || state == S_WB;
  assign wa = state == S_WB ? ir[RD_LSB +: 2] : ir[LDI_RD_LSB +: 2];
  assign wd = state == S_WB ? alu_out : ir[DW-1:0];
  assign rom_addr = pc;
  assign busy = state inside {S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_WB};
  assign halted = state == S_HALT;
  alu_seq_regfile u_regfile (
    .clk(clk),
    .rst(rst),
    .we(we),
    .wa(wa),
    .wd(wd),
    .ra(ir[RD_LSB +: 2]),
    .rb(ir[RS_LSB +: 2]),
    .a_data(a_data),
    .b_data(b_data)
  );
  always_ff @(posedge clk)
    if (rst) state <= S_IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      S_IDLE:   next = start ? S_FETCH : S_IDLE;
      S_FETCH:  next = S_WAIT;
      S_WAIT:   next = S_DECODE;
      S_DECODE: next = S_EXEC;
      S_EXEC:   next = cls == CLS_ALU ? S_WB : cls == CLS_HALT ? S_HALT : S_FETCH;
      S_WB:     next = S_FETCH;
      S_HALT:   next = start ? S_FETCH : S_HALT;
      default:  next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      pc <= '0;
      ir <= '0;
      a_q <= '0;
      b_q <= '0;
      sel_q <= '0;
      flag_z <= 1'b0;
      flag_co <= 1'b0;
    end else begin
      if (state == S_DECODE) begin
        ir <= rom_data;
        pc <= pc + PC_W'(1);
      end
      if (state == S_EXEC && cls == CLS_BR && taken) pc <= ir[PC_W-1:0];
      if (state == S_HALT && start) pc <= '0;
      if (alu_drive) begin
        a_q <= a_data;
        b_q <= b_data;
        sel_q <= ir[SEL_LSB +: 2];
      end
      if (state == S_WB) begin
        flag_z <= alu_z;
        flag_co <= alu_co;
      end
    end
`ifdef ALU_SEQ_PERF_EN
  logic retire;
  assign retire = (state == S_EXEC && cls != CLS_ALU) || state == S_WB;
  always_ff @(posedge clk)
    if (rst) retired_cnt <= '0;
    else if (retire && retired_cnt != 16'hFFFF) retired_cnt <= retired_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed scoreboard bench for alu_sequencer with a bench-side ROM and ALU
module tb_alu_sequencer;
  localparam int K_ADDR = 0, K_A = 1, K_B = 2, K_SEL = 3, K_Z = 4, K_CO = 5, K_HALT = 6, K_BUSY = 7;
  typedef struct {
    int cyc;
    int kind;
    logic [7:0] val;
  } exp_t;
  logic clk = 0, rst = 1, start = 0;
  logic [7:0] rom_addr, alu_a, alu_b, alu_out;
  logic [11:0] rom_data;
  logic [1:0] alu_sel;
  logic alu_co, alu_z, flag_z, flag_co, busy, halted;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0] retired_cnt;
`endif
  logic [11:0] rom [256];
  logic [7:0] snap [8][512];
  exp_t sb[$];
  int total = 0, bad = 0, t;
  logic [7:0] m_r [4];
  logic [7:0] m_pc;
  logic m_z, m_co;

  alu_sequencer dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_sel(alu_sel),
    .alu_out(alu_out),
    .alu_co(alu_co),
    .alu_z(alu_z),
    .flag_z(flag_z),
    .flag_co(flag_co),
    .busy(busy),
`ifdef ALU_SEQ_PERF_EN
    .retired_cnt(retired_cnt),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [8:0] alu_fn(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      2'b00:   return {1'b0, a & b};
      2'b01:   return {1'b0, a ^ b};
      2'b10:   return {1'b0, a} + {1'b0, b};
      default: return {a[7], a[6:0], a[7]};
    endcase
  endfunction

  always_comb begin
    {alu_co, alu_out} = alu_fn(alu_sel, alu_a, alu_b);
    alu_z = alu_out == 8'h00;
  end

  function automatic logic [11:0] op_alu(input logic [1:0] s, input logic [1:0] rd, input logic [1:0] rs);
    return {2'b00, s, rd, rs, 4'h0};
  endfunction
  function automatic logic [11:0] op_ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {2'b01, rd, imm};
  endfunction
  function automatic logic [11:0] op_br(input logic [1:0] cond, input logic [7:0] tgt);
    return {2'b10, cond, tgt};
  endfunction
  localparam logic [11:0] OP_HALT = 12'hC00;

  function automatic string kname(input int k);
    case (k)
      K_ADDR:  return "rom_addr";
      K_A:     return "alu_a";
      K_B:     return "alu_b";
      K_SEL:   return "alu_sel";
      K_Z:     return "flag_z";
      K_CO:    return "flag_co";
      K_HALT:  return "halted";
      default: return "busy";
    endcase
  endfunction

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input int c, input int k, input logic [7:0] v);
    exp_t e;
    e.cyc = c;
    e.kind = k;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_z = 0;
    m_co = 0;
    m_pc = 0;
  endtask

  // ISA-level model: walks the ROM from m_pc, queues expected observations by cycle index
  // (cycle 1 = first FETCH after start is sampled).
  task automatic walk(input int max_ins, output int tend);
    logic [11:0] ins;
    logic [8:0] r;
    logic [7:0] a, b;
    int n, tt;
    tt = 1;
    n = 0;
    while (n < max_ins) begin
      ins = rom[m_pc];
      push(tt, K_ADDR, m_pc);
      push(tt, K_BUSY, 8'd1);
      m_pc = m_pc + 8'd1;
      n++;
      case (ins[11:10])
        2'b00: begin
          a = m_r[ins[7:6]];
          b = m_r[ins[5:4]];
          r = alu_fn(ins[9:8], a, b);
          push(tt + 3, K_A, a);
          push(tt + 3, K_B, b);
          push(tt + 3, K_SEL, {6'd0, ins[9:8]});
          m_r[ins[7:6]] = r[7:0];
          m_z = r[7:0] == 8'h00;
          m_co = r[8];
          push(tt + 5, K_Z, {7'd0, m_z});
          push(tt + 5, K_CO, {7'd0, m_co});
          tt += 5;
        end
        2'b01: begin
          m_r[ins[9:8]] = ins[7:0];
          push(tt + 4, K_Z, {7'd0, m_z});
          push(tt + 4, K_CO, {7'd0, m_co});
          tt += 4;
        end
        2'b10: begin
          if (ins[9:8] == 2'b00 || (ins[9:8] == 2'b01 && m_z) || (ins[9:8] == 2'b10 && m_co)) m_pc = ins[7:0];
          tt += 4;
        end
        default: begin
          push(tt + 4, K_HALT, 8'd1);
          push(tt + 4, K_BUSY, 8'd0);
          m_pc = 0;
          tt += 4;
          n = max_ins;
        end
      endcase
    end
    tend = tt;
  endtask

  // Pulses start, records outputs each cycle; s1/s2 are extra start samples, rc a reset sample.
  task automatic run(input int ncyc, input int s1, input int s2, input int rc);
    exp_t e;
    @(negedge clk);
    start = 1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      @(negedge clk);
      snap[K_ADDR][c] = rom_addr;
      snap[K_A][c] = alu_a;
      snap[K_B][c] = alu_b;
      snap[K_SEL][c] = {6'd0, alu_sel};
      snap[K_Z][c] = {7'd0, flag_z};
      snap[K_CO][c] = {7'd0, flag_co};
      snap[K_HALT][c] = {7'd0, halted};
      snap[K_BUSY][c] = {7'd0, busy};
      start = (c + 1 == s1) || (c + 1 == s2);
      rst = (c + 1 == rc);
    end
    start = 0;
    rst = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmp($sformatf("%s@%0d", kname(e.kind), e.cyc), {8'd0, snap[e.kind][e.cyc]}, {8'd0, e.val});
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = OP_HALT;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("reset_rom_addr", {8'd0, rom_addr}, 16'd0);
    cmp("reset_alu_a", {8'd0, alu_a}, 16'd0);
    cmp("reset_alu_b", {8'd0, alu_b}, 16'd0);
    cmp("reset_alu_sel", {14'd0, alu_sel}, 16'd0);
    cmp("reset_flags", {14'd0, flag_z, flag_co}, 16'd0);
    cmp("reset_status", {14'd0, busy, halted}, 16'd0);
    rst = 0;
    model_reset();
    // P1: r0 = F0 + 0F, halted 18 cycles after start
    rom[0] = op_ldi(0, 8'hF0);
    rom[1] = op_ldi(1, 8'h0F);
    rom[2] = op_alu(2'b10, 0, 1);
    rom[3] = OP_HALT;
    walk(100, t);
    push(17, K_HALT, 8'd0);
    push(18, K_HALT, 8'd1);
    run(t, -1, -1, -1);
`ifdef ALU_SEQ_PERF_EN
    cmp("retired_cnt", retired_cnt, 16'd4);
`endif
    // P2: r0 readback, ADD 80+80 sets Z and CO, branch-if-Z to 0x10
    rom[0] = op_alu(2'b00, 0, 0);
    rom[1] = op_ldi(2, 8'h80);
    rom[2] = op_ldi(3, 8'h80);
    rom[3] = op_alu(2'b10, 2, 3);
    rom[4] = op_br(2'b01, 8'h10);
    rom[16] = op_alu(2'b00, 2, 2);
    rom[17] = OP_HALT;
    walk(100, t);
    run(t, -1, -1, -1);
    // P3: circular shift of 81 gives 03 with carry out
    rom[0] = op_ldi(1, 8'h81);
    rom[1] = op_alu(2'b11, 1, 0);
    rom[2] = op_alu(2'b00, 1, 1);
    rom[3] = OP_HALT;
    walk(100, t);
    run(t, -1, -1, -1);
    // P4: XOR self clears, LDI keeps Z, never-branch falls through
    rom[0] = op_ldi(0, 8'h5A);
    rom[1] = op_alu(2'b01, 0, 0);
    rom[2] = op_ldi(0, 8'h01);
    rom[3] = op_br(2'b11, 8'h20);
    rom[4] = OP_HALT;
    walk(100, t);
    run(t, -1, -1, -1);
    // P5: pc wraps FF -> 00, then reset during WB of an ADD
    rom[0] = op_br(2'b01, 8'hFE);
    rom[1] = op_alu(2'b10, 2, 3);
    rom[254] = op_alu(2'b10, 1, 1);
    rom[255] = op_ldi(3, 8'h77);
    walk(4, t);
    push(t, K_ADDR, 8'd1);
    push(t + 3, K_SEL, 8'd2);
    for (int k = 0; k < 8; k++) push(t + 5, k, 8'd0);
    run(t + 5, -1, -1, t + 5);
    model_reset();
    // P6: start pulses while busy and during WB are ignored
    rom[0] = op_ldi(0, 8'h33);
    rom[1] = op_alu(2'b00, 0, 0);
    rom[2] = OP_HALT;
    walk(100, t);
    run(t, 3, 10, -1);
    // P7: restart from HALT at pc 0 with registers retained
    rom[0] = op_alu(2'b00, 0, 0);
    rom[1] = OP_HALT;
    walk(100, t);
    run(t, -1, -1, -1);
    // start coincident with rst is ignored
    @(negedge clk);
    rst = 1;
    start = 1;
    @(negedge clk);
    rst = 0;
    start = 0;
    cmp("rst_start_status0", {14'd0, busy, halted}, 16'd0);
    @(negedge clk);
    cmp("rst_start_status1", {14'd0, busy, halted}, 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
